// File: rtl/game_ctrl.sv
// Game sequencer: FSM, datapath feedback registers, button edge capture,
// gravity tick, saturating score and game-over detection.
module game_ctrl #(
  parameter int DROP_TICKS = 16,
  parameter int SCORE_W    = 8
) (
  input  logic               clka,
  input  logic               restart,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_rotate,
  input  logic               touched,
  input  logic               error_in,
  input  logic [31:0]        board_dp,
  input  logic [4:0]         location_dp,
  input  logic [1:0]         rotation_dp,
  output logic [2:0]         state,
  output logic [2:0]         old_state,
  output logic [1:0]         move,
  output logic               drop,
  output logic [31:0]        board_out,
  output logic [4:0]         location_out,
  output logic [1:0]         rotation_out,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  typedef enum logic [2:0] {
    S_GEN      = 3'd0,
    S_MOVE     = 3'd1,
    S_LAND     = 3'd2,
    S_CLEAR    = 3'd3,
    S_NEWBOARD = 3'd4,
    S_GAMEOVER = 3'd5
  } state_t;

  localparam int TW = $clog2(DROP_TICKS);

  state_t               r_state, r_old, w_next;
  logic [TW-1:0]        r_tick;
  logic [2:0]           r_prev, r_pend, w_clr, w_btn, w_rise;
  logic                 r_gap;
  logic [1:0]           w_move;
  logic                 w_drop;
  logic [31:0]          r_board;
  logic [4:0]           r_loc;
  logic [1:0]           r_rot;
  logic [SCORE_W-1:0]   r_score;

  function automatic logic [3:0] count_full(input logic [31:0] b);
    logic [3:0] n;
    n = 4'd0;
    for (int r = 0; r < 8; r++)
      if (b[4*r +: 4] == 4'hF) n = n + 4'd1;
    return n;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                 input logic [3:0] n);
    logic [SCORE_W+4:0] sum;
    sum = {5'd0, s} + {{(SCORE_W+1){1'b0}}, n};
    if (sum > {5'd0, {SCORE_W{1'b1}}}) return {SCORE_W{1'b1}};
    return sum[SCORE_W-1:0];
  endfunction

  assign w_btn  = {btn_rotate, btn_right, btn_left};
  assign w_rise = w_btn & ~r_prev;
  assign w_drop = (r_state == S_MOVE) && (r_tick == TW'(DROP_TICKS - 1));

  always_comb begin
    w_next = r_state;
    w_move = 2'd0;
    w_clr  = 3'b000;
    case (r_state)
      S_GEN:  w_next = S_MOVE;
      S_MOVE: begin
        // r_gap forces an idle cycle after every issued move
        if (!r_gap) begin
          if (r_pend[0]) begin
            w_move = 2'd1;
            w_clr  = 3'b001;
          end else if (r_pend[1]) begin
            w_move = 2'd2;
            w_clr  = 3'b010;
          end else if (r_pend[2]) begin
            w_move = 2'd3;
            w_clr  = 3'b100;
          end
        end
        if (touched) w_next = S_LAND;
      end
      S_LAND:     w_next = S_CLEAR;
      S_CLEAR:    w_next = S_NEWBOARD;
      S_NEWBOARD: w_next = ((board_dp[31:28] != 4'h0) || error_in) ? S_GAMEOVER : S_GEN;
      S_GAMEOVER: w_next = S_GAMEOVER;
      default:    w_next = S_GEN;
    endcase
  end

  always_ff @(posedge clka) begin
    if (restart) begin
      r_state <= S_GEN;
      r_old   <= S_GEN;
      r_tick  <= '0;
      r_prev  <= 3'b000;
      r_pend  <= 3'b000;
      r_gap   <= 1'b0;
      r_board <= 32'd0;
      r_loc   <= 5'd0;
      r_rot   <= 2'd0;
      r_score <= '0;
    end else begin
      r_state <= w_next;
      r_old   <= r_state;
      r_prev  <= w_btn;
      r_gap   <= (w_move != 2'd0);
      if (w_next == S_GEN) r_pend <= 3'b000;
      else                 r_pend <= (r_pend & ~w_clr) | w_rise;
      if (r_state == S_GEN) r_tick <= '0;
      else if (r_state == S_MOVE)
        r_tick <= w_drop ? '0 : r_tick + TW'(1);
      if (r_state inside {S_MOVE, S_LAND, S_CLEAR, S_NEWBOARD}) r_board <= board_dp;
      if (r_state == S_MOVE) begin
        r_loc <= location_dp;
        r_rot <= rotation_dp;
      end
      if (r_state == S_LAND) r_score <= sat_add(r_score, count_full(board_dp));
    end
  end

  assign state        = r_state;
  assign old_state    = r_old;
  assign move         = w_move;
  assign drop         = w_drop;
  assign board_out    = r_board;
  assign location_out = r_loc;
  assign rotation_out = r_rot;
  assign score        = r_score;
  assign game_over    = (r_state == S_GAMEOVER);

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: reset, gravity, moves, landing/score,
// saturation, game over and restart behaviour.
module tb_game_ctrl;
  logic        clka = 1'b0;
  logic        restart, btn_left, btn_right, btn_rotate, touched, error_in;
  logic [31:0] board_dp;
  logic [4:0]  location_dp;
  logic [1:0]  rotation_dp;
  logic [2:0]  state, old_state;
  logic [1:0]  move;
  logic        drop;
  logic [31:0] board_out;
  logic [4:0]  location_out;
  logic [1:0]  rotation_out;
  logic [7:0]  score;
  logic        game_over;

  int checks = 0;
  int failures = 0;
  int exp_score = 0;

  game_ctrl #(.DROP_TICKS(16), .SCORE_W(8)) dut (
    .clka(clka), .restart(restart), .btn_left(btn_left), .btn_right(btn_right),
    .btn_rotate(btn_rotate), .touched(touched), .error_in(error_in),
    .board_dp(board_dp), .location_dp(location_dp), .rotation_dp(rotation_dp),
    .state(state), .old_state(old_state), .move(move), .drop(drop),
    .board_out(board_out), .location_out(location_out), .rotation_out(rotation_out),
    .score(score), .game_over(game_over)
  );

  always #5 clka = ~clka;

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_state"}, {29'd0, state}, 32'd0);
    chk({tag, "_old"}, {29'd0, old_state}, 32'd0);
    chk({tag, "_move"}, {30'd0, move}, 32'd0);
    chk({tag, "_drop"}, {31'd0, drop}, 32'd0);
    chk({tag, "_board"}, board_out, 32'd0);
    chk({tag, "_loc"}, {27'd0, location_out}, 32'd0);
    chk({tag, "_rot"}, {30'd0, rotation_out}, 32'd0);
    chk({tag, "_score"}, {24'd0, score}, 32'd0);
    chk({tag, "_go"}, {31'd0, game_over}, 32'd0);
  endtask

  // From MOVE: land with board b (rows = hand-counted full rows), clear board, back to MOVE
  task automatic land(input logic [31:0] b, input int rows);
    board_dp = b; touched = 1'b1;
    tick();
    touched = 1'b0;
    tick();
    exp_score = (exp_score + rows > 255) ? 255 : exp_score + rows;
    chk("land_score", {24'd0, score}, exp_score);
    board_dp = 32'd0;
    tick();
    tick();
    chk("land_gen", {29'd0, state}, 32'd0);
    tick();
  endtask

  initial begin
    restart = 1'b1; btn_left = 1'b0; btn_right = 1'b0; btn_rotate = 1'b0;
    touched = 1'b0; error_in = 1'b0; board_dp = 32'h0000_0012;
    location_dp = 5'd7; rotation_dp = 2'd1;
    tick(); tick();
    chk_zero_outputs("reset");
    restart = 1'b0;

    // GEN -> MOVE, then gravity pulses on MOVE cycles 16/32/48
    tick();
    chk("gen_to_move", {29'd0, state}, 32'd1);
    chk("gen_old", {29'd0, old_state}, 32'd0);
    for (int n = 1; n <= 48; n++) begin
      chk($sformatf("drop_c%0d", n), {31'd0, drop}, {31'd0, (n % 16 == 0)});
      if (n % 16 == 0) chk($sformatf("move_idle_c%0d", n), {30'd0, move}, 32'd0);
      tick();
    end
    chk("move_board", board_out, 32'h0000_0012);
    chk("move_loc", {27'd0, location_out}, 32'd7);
    chk("move_rot", {30'd0, rotation_out}, 32'd1);

    // left + rotate rising together
    btn_left = 1'b1; btn_rotate = 1'b1;
    tick();
    chk("mv_left", {30'd0, move}, 32'd1);
    btn_left = 1'b0; btn_rotate = 1'b0;
    tick();
    chk("mv_gap", {30'd0, move}, 32'd0);
    tick();
    chk("mv_rot", {30'd0, move}, 32'd3);
    tick();
    chk("mv_after", {30'd0, move}, 32'd0);
    tick();
    chk("mv_after2", {30'd0, move}, 32'd0);

    // landing with two full rows
    board_dp = 32'h0000_00FF; touched = 1'b1;
    tick();
    touched = 1'b0;
    chk("land_state", {29'd0, state}, 32'd2);
    chk("land_old", {29'd0, old_state}, 32'd1);
    chk("land_move", {30'd0, move}, 32'd0);
    tick();
    exp_score = 2;
    chk("clear_state", {29'd0, state}, 32'd3);
    chk("clear_old", {29'd0, old_state}, 32'd2);
    chk("score2", {24'd0, score}, 32'd2);
    tick();
    chk("nb_state", {29'd0, state}, 32'd4);
    chk("nb_old", {29'd0, old_state}, 32'd3);
    tick();
    chk("gen2_state", {29'd0, state}, 32'd0);
    chk("gen2_old", {29'd0, old_state}, 32'd4);
    tick();

    // climb to 254, then saturate
    for (int k = 0; k < 31; k++) land(32'hFFFF_FFFF, 8);
    land(32'h0000_FFFF, 4);
    chk("score254", {24'd0, score}, 32'd254);
    land(32'hFFFF_FFFF, 8);
    chk("score_sat", {24'd0, score}, 32'd255);
    land(32'hFFFF_FFFF, 8);
    chk("score_sat2", {24'd0, score}, 32'd255);

    // error_in at NEWBOARD with empty top row
    board_dp = 32'h0000_0001; touched = 1'b1;
    tick(); touched = 1'b0;
    tick(); tick();
    error_in = 1'b1;
    chk("err_nb", {29'd0, state}, 32'd4);
    tick();
    error_in = 1'b0;
    chk("err_go_state", {29'd0, state}, 32'd5);
    chk("err_go_flag", {31'd0, game_over}, 32'd1);
    restart = 1'b1;
    tick();
    chk_zero_outputs("rst_after_err");
    restart = 1'b0;
    tick(); tick();
    chk("move_again", {29'd0, state}, 32'd1);

    // top row occupied at NEWBOARD, then GAMEOVER is sticky
    board_dp = 32'h0000_0000; touched = 1'b1;
    tick(); touched = 1'b0;
    tick();
    board_dp = 32'h1000_0000;
    tick();
    tick();
    chk("go_state", {29'd0, state}, 32'd5);
    chk("go_flag", {31'd0, game_over}, 32'd1);
    chk("go_board", board_out, 32'h1000_0000);
    board_dp = 32'hABCD_0123; touched = 1'b1;
    for (int n = 0; n < 6; n++) begin
      btn_left = n[0]; btn_right = n[1]; btn_rotate = ~n[0];
      tick();
      chk("go_hold_state", {29'd0, state}, 32'd5);
      chk("go_hold_move", {30'd0, move}, 32'd0);
      chk("go_hold_drop", {31'd0, drop}, 32'd0);
      chk("go_hold_board", board_out, 32'h1000_0000);
    end
    touched = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_rotate = 1'b0;
    restart = 1'b1;
    tick();
    chk_zero_outputs("rst_after_go");
    restart = 1'b0;
    board_dp = 32'h0000_0055;
    tick(); tick(); tick();

    // restart mid-MOVE with right still pending
    btn_left = 1'b1; btn_right = 1'b1;
    tick();
    chk("pend_left", {30'd0, move}, 32'd1);
    restart = 1'b1; btn_left = 1'b0; btn_right = 1'b0;
    tick();
    chk("mid_state", {29'd0, state}, 32'd0);
    chk("mid_move", {30'd0, move}, 32'd0);
    chk("mid_board", board_out, 32'd0);
    chk("mid_score", {24'd0, score}, 32'd0);
    restart = 1'b0;
    tick();
    for (int n = 0; n < 5; n++) begin
      chk("no_stale_move", {30'd0, move}, 32'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
